// File: rtl/dnn_pkg.sv
// Shared definitions for the layer-1 to layer-2 activation path.
// relu_requant is the reference lane transform also used by the layer-2 bench model.
package dnn_pkg;

  localparam int MAC_W = 17;
  localparam int ACT_W = 7;
  localparam int LANES = 4;

  typedef struct packed {
    logic [ACT_W-1:0] val;
    logic             sat;
  } act_t;

  // ReLU, round-half-up right shift, then clip to the positive activation range.
  function automatic act_t relu_requant(input logic signed [MAC_W-1:0] v, input int shift);
    logic [MAC_W-1:0] r;
    logic [MAC_W-1:0] q;
    act_t             res;
    r       = v[MAC_W-1] ? '0 : MAC_W'(v);
    q       = (r + (MAC_W'(1) << (shift - 1))) >> shift;
    res.sat = q > MAC_W'(2 ** (ACT_W - 1) - 1);
    res.val = res.sat ? ACT_W'(2 ** (ACT_W - 1) - 1) : q[ACT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/dnn_vec_fifo.sv
// Synchronous vector FIFO; a push while full is taken only when a pop happens in the same cycle.
module dnn_vec_fifo
  import dnn_pkg::*;
#(
  parameter int WIDTH = LANES * ACT_W,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dnn_relu_requant.sv
// ReLU + rounded requantization between layer 1 and layer 2, buffered so layer 1 never stalls.
// S1 rounds/shifts, S2 saturates and pushes into the FIFO, whose head drives x0..x3.
module dnn_relu_requant
  import dnn_pkg::*;
#(
  parameter int IN_SIZE  = MAC_W,
  parameter int OUT_SIZE = ACT_W,
  parameter int SHIFT    = 4,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mac_ready,
  input  logic signed [IN_SIZE-1:0]  in4,
  input  logic signed [IN_SIZE-1:0]  in5,
  input  logic signed [IN_SIZE-1:0]  in6,
  input  logic signed [IN_SIZE-1:0]  in7,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [OUT_SIZE-1:0] x0,
  output logic signed [OUT_SIZE-1:0] x1,
  output logic signed [OUT_SIZE-1:0] x2,
  output logic signed [OUT_SIZE-1:0] x3,
  input  logic                       clr_err,
  output logic                       ovf_err,
  output logic [7:0]                 sat_cnt
);

  localparam int CW = $clog2(DEPTH);
  localparam int VW = LANES * OUT_SIZE;
  localparam logic [IN_SIZE-1:0] ROUND = IN_SIZE'(2 ** (SHIFT - 1));
  localparam logic [IN_SIZE-1:0] QMAX  = IN_SIZE'(2 ** (OUT_SIZE - 1) - 1);

  logic signed [IN_SIZE-1:0] in_v     [LANES];
  logic [IN_SIZE-1:0]        relu_v   [LANES];
  logic [IN_SIZE-1:0]        q_next   [LANES];
  logic [IN_SIZE-1:0]        s1_q     [LANES];
  logic                      s1_vld;
  logic [OUT_SIZE-1:0]       lane_val [LANES];
  logic [LANES-1:0]          lane_sat;
  logic [2:0]                sat_lanes;
  logic [VW-1:0]             push_vec;
  logic [VW-1:0]             head_vec;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CW:0]               fifo_count;
  logic                      pop;
  logic                      accept;
  logic                      drop;
  logic [8:0]                sat_sum;

  assign in_v[0] = in4;
  assign in_v[1] = in5;
  assign in_v[2] = in6;
  assign in_v[3] = in7;

  // The full IN_SIZE width holds r + ROUND without overflow since r is non-negative.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      relu_v[i] = in_v[i][IN_SIZE-1] ? '0 : IN_SIZE'(in_v[i]);
      q_next[i] = (relu_v[i] + ROUND) >> SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_q[i] <= '0;
    end else begin
      s1_vld <= mac_ready;
      if (mac_ready) begin
        for (int i = 0; i < LANES; i++) s1_q[i] <= q_next[i];
      end
    end
  end

  always_comb begin
    sat_lanes = '0;
    push_vec  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sat[i] = s1_q[i] > QMAX;
      lane_val[i] = lane_sat[i] ? QMAX[OUT_SIZE-1:0] : s1_q[i][OUT_SIZE-1:0];
      sat_lanes   = sat_lanes + 3'(lane_sat[i]);
      push_vec[i*OUT_SIZE +: OUT_SIZE] = lane_val[i];
    end
  end

  assign pop     = out_valid && out_ready;
  assign accept  = s1_vld && (!fifo_full || pop);
  assign drop    = s1_vld && fifo_full && !pop;
  assign sat_sum = {1'b0, sat_cnt} + 9'(sat_lanes);

  dnn_vec_fifo #(
    .WIDTH (VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (push_vec),
    .dout  (head_vec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A drop in the same cycle as a clear keeps the flag set; a clear keeps only this cycle's saturations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (drop)         ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;
      if (clr_err)      sat_cnt <= accept ? 8'(sat_lanes) : 8'd0;
      else if (accept)  sat_cnt <= sat_sum[8] ? 8'hFF : sat_sum[7:0];
    end
  end

  assign out_valid = (fifo_count != '0);
  assign x0 = fifo_empty ? '0 : head_vec[0*OUT_SIZE +: OUT_SIZE];
  assign x1 = fifo_empty ? '0 : head_vec[1*OUT_SIZE +: OUT_SIZE];
  assign x2 = fifo_empty ? '0 : head_vec[2*OUT_SIZE +: OUT_SIZE];
  assign x3 = fifo_empty ? '0 : head_vec[3*OUT_SIZE +: OUT_SIZE];

endmodule

// File: tb/tb_dnn_relu_requant.sv
// Directed and randomized bench for dnn_relu_requant against a queue-based model
// that applies the ReLU/round/saturate rules with integer arithmetic.
module tb_dnn_relu_requant;

  localparam int SHIFT = 4;
  localparam int DEPTH = 4;
  localparam int AMAX  = 63;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               mac_ready;
  logic signed [16:0] in4, in5, in6, in7;
  logic               out_ready;
  logic               out_valid;
  logic signed [6:0]  x0, x1, x2, x3;
  logic               clr_err;
  logic               ovf_err;
  logic [7:0]         sat_cnt;

  int vectors = 0;
  int miscompares = 0;

  int          cur_in [4];
  logic [27:0] mq [$];
  bit          m_pend;
  int          m_pend_in [4];
  int          m_sat;
  bit          m_ovf;

  dnn_relu_requant #(.IN_SIZE(17), .OUT_SIZE(7), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mac_ready (mac_ready),
    .in4       (in4),
    .in5       (in5),
    .in6       (in6),
    .in7       (in7),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .clr_err   (clr_err),
    .ovf_err   (ovf_err),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic int lane_q(int v);
    int r;
    r = (v < 0) ? 0 : v;
    return (r + 2 ** (SHIFT - 1)) / (2 ** SHIFT);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 0;
    m_sat  = 0;
    m_ovf  = 0;
  endtask

  // Advances the model by one rising edge using the inputs held across it.
  task automatic model_edge();
    bit          pop;
    bit          acc;
    bit          drp;
    int          nsat;
    int          q;
    logic [27:0] vec;
    pop  = (mq.size() != 0) && out_ready;
    acc  = 0;
    drp  = 0;
    nsat = 0;
    vec  = '0;
    if (m_pend) begin
      for (int i = 0; i < 4; i++) begin
        q = lane_q(m_pend_in[i]);
        if (q > AMAX) begin
          nsat++;
          q = AMAX;
        end
        vec[i*7 +: 7] = 7'(q);
      end
      if (mq.size() < DEPTH || pop) acc = 1;
      else drp = 1;
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(vec);
    if (drp) m_ovf = 1;
    else if (clr_err) m_ovf = 0;
    if (clr_err) m_sat = acc ? nsat : 0;
    else if (acc) m_sat = (m_sat + nsat > 255) ? 255 : m_sat + nsat;
    m_pend = mac_ready;
    for (int i = 0; i < 4; i++) m_pend_in[i] = cur_in[i];
  endtask

  task automatic check_output(input string tag);
    logic [27:0] head;
    head = (mq.size() != 0) ? mq[0] : 28'd0;
    cmp({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    cmp({tag, ".x0"}, 32'(x0), 32'(head[6:0]));
    cmp({tag, ".x1"}, 32'(x1), 32'(head[13:7]));
    cmp({tag, ".x2"}, 32'(x2), 32'(head[20:14]));
    cmp({tag, ".x3"}, 32'(x3), 32'(head[27:21]));
    cmp({tag, ".ovf_err"}, 32'(ovf_err), 32'(m_ovf));
    cmp({tag, ".sat_cnt"}, 32'(sat_cnt), 32'(m_sat));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_edge();
    check_output(tag);
  endtask

  task automatic apply_stimulus(input bit mr, input int a, input int b, input int c, input int d,
                                input bit ordy, input bit clr, input string tag);
    mac_ready = mr;
    cur_in[0] = a;
    cur_in[1] = b;
    cur_in[2] = c;
    cur_in[3] = d;
    in4 = 17'(a);
    in5 = 17'(b);
    in6 = 17'(c);
    in7 = 17'(d);
    out_ready = ordy;
    clr_err   = clr;
    step(tag);
  endtask

  task automatic idle(input bit ordy, input bit clr, input string tag);
    apply_stimulus(0, 0, 0, 0, 0, ordy, clr, tag);
  endtask

  task automatic fill_full();
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 3000 + 100 * i, 16 * i, -5, 1016, 0, 0, "fill");
    idle(0, 0, "fill_settle");
    idle(0, 0, "fill_settle");
  endtask

  initial begin
    rst_n = 1'b0;
    mac_ready = 0; out_ready = 0; clr_err = 0;
    in4 = '0; in5 = '0; in6 = '0; in7 = '0;
    for (int i = 0; i < 4; i++) cur_in[i] = 0;
    model_reset();
    #3;
    check_output("reset");
    step("reset_hold");
    rst_n = 1'b1;

    // ReLU and round-half-up, with two-cycle latency into an empty FIFO.
    apply_stimulus(1, 100, -50, 7, 8, 1, 0, "t1_pulse");
    cmp("t1_lat1.out_valid", 32'(out_valid), 32'd0);
    idle(1, 0, "t1_s1");
    cmp("t1.out_valid", 32'(out_valid), 32'd1);
    cmp("t1.x0", 32'(x0), 32'd6);
    cmp("t1.x1", 32'(x1), 32'd0);
    cmp("t1.x2", 32'(x2), 32'd0);
    cmp("t1.x3", 32'(x3), 32'd1);
    cmp("t1.sat_cnt", 32'(sat_cnt), 32'd0);
    idle(1, 0, "t1_drain");

    // Saturation boundary at 1015/1016.
    apply_stimulus(1, 2000, 1015, 1016, -65536, 1, 0, "t2_pulse");
    idle(1, 0, "t2_s1");
    cmp("t2.x0", 32'(x0), 32'd63);
    cmp("t2.x1", 32'(x1), 32'd63);
    cmp("t2.x2", 32'(x2), 32'd63);
    cmp("t2.x3", 32'(x3), 32'd0);
    cmp("t2.sat_cnt", 32'(sat_cnt), 32'd2);
    idle(1, 0, "t2_drain");

    // Backpressure, overflow drop, then in-order drain.
    fill_full();
    cmp("t3_full.out_valid", 32'(out_valid), 32'd1);
    apply_stimulus(1, 500, 500, 500, 500, 0, 0, "t3_fifth");
    idle(0, 0, "t3_drop");
    cmp("t3.ovf_err", 32'(ovf_err), 32'd1);
    idle(0, 0, "t3_hold");
    for (int i = 0; i < DEPTH; i++) idle(1, 0, "t3_drain");
    cmp("t3_empty.out_valid", 32'(out_valid), 32'd0);

    // Full FIFO with a pop coinciding with the S2 push.
    idle(0, 1, "t4_clr");
    cmp("t4_clr.ovf_err", 32'(ovf_err), 32'd0);
    fill_full();
    apply_stimulus(1, 1200, 40, 80, 160, 0, 0, "t4_pulse");
    idle(1, 0, "t4_pushpop");
    idle(0, 0, "t4_hold");
    cmp("t4.ovf_err", 32'(ovf_err), 32'd0);
    for (int i = 0; i < DEPTH; i++) idle(1, 0, "t4_drain");
    cmp("t4_empty.out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset with three vectors queued.
    for (int i = 0; i < 3; i++) apply_stimulus(1, 4000, 100 * i, 2000, 9, 0, 0, "t5_fill");
    idle(0, 0, "t5_settle");
    idle(0, 0, "t5_settle");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("t5_reset");
    cmp("t5_reset.out_valid", 32'(out_valid), 32'd0);
    cmp("t5_reset.sat_cnt", 32'(sat_cnt), 32'd0);
    step("t5_reset_hold");
    rst_n = 1'b1;
    apply_stimulus(1, 300, 200, 100, 50, 0, 0, "t5_pulse");
    cmp("t5_lat1.out_valid", 32'(out_valid), 32'd0);
    idle(0, 0, "t5_s1");
    cmp("t5_lat2.out_valid", 32'(out_valid), 32'd1);
    cmp("t5.x0", 32'(x0), 32'd19);
    idle(1, 0, "t5_drain");

    // Clear coinciding with a drop: the set wins, a lone clear then takes effect.
    fill_full();
    apply_stimulus(1, 700, 700, 700, 700, 0, 0, "t6_pulse");
    idle(0, 1, "t6_drop_clr");
    cmp("t6.ovf_err", 32'(ovf_err), 32'd1);
    idle(0, 1, "t6_clr");
    cmp("t6_clr.ovf_err", 32'(ovf_err), 32'd0);
    for (int i = 0; i < DEPTH; i++) idle(1, 0, "t6_drain");

    // Randomized traffic with random backpressure and occasional clears.
    for (int n = 0; n < 400; n++) begin
      int v [4];
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 0) v[i] = int'($urandom_range(0, 1100)) - 100;
        else v[i] = int'($urandom_range(0, 131071)) - 65536;
      end
      apply_stimulus(bit'($urandom_range(0, 1)), v[0], v[1], v[2], v[3],
                     bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 31) == 0), "rand");
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1, 0, "final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
